mario_power_ctrl: RTL and testbench

Power-state controller for the Mario sprite block. It turns gameplay events from collision detection into the one-cycle `upgrade_impulse`, `downgrade_impulse` and `hero_impulse` strobes that Mario consumes. It owns the authoritative small/big/dead state, the star (hero) timer and the post-damage grace timer. It sits between the collision/pickup logic and Mario, and is clocked on the main game clock, with a one-cycle frame strobe as timebase.

---
 rtl/mario_power_ctrl.sv | 144 ++++++++++++++
 tb/tb_mario_power_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mario_power_ctrl.sv
// rtl/mario_power_ctrl.sv - Mario power state (small/big/dead), star and grace timers, impulse strobes.
// Optional post-damage grace timer enabled by defining MARIO_PWR_HURT_GRACE_EN.
module mario_power_ctrl #(
  parameter int CNT_W      = 10,
  parameter int STAR_TICKS = 600,
  parameter int HURT_TICKS = 120
) (
  input  logic clk,
  input  logic rstn,
  input  logic tick,
  input  logic get_mushroom,
  input  logic get_star,
  input  logic enemy_hit,
  input  logic fall_pit,
  input  logic respawn,
  output logic upgrade_impulse,
  output logic downgrade_impulse,
  output logic hero_impulse,
  output logic level,
  output logic hero,
  output logic blink,
  output logic dead
);

  typedef enum logic [1:0] {
    SMALL = 2'd0,
    BIG   = 2'd1,
    DEAD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STAR_LD = CNT_W'(STAR_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // Timer loads must fit the counters, otherwise they would silently truncate.
  if (STAR_TICKS >= (1 << CNT_W) || HURT_TICKS >= (1 << CNT_W)) begin : g_bad_ticks
    $error("mario_power_ctrl: STAR_TICKS/HURT_TICKS do not fit in CNT_W bits");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] star_q, star_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             hr_q, hr_d;
  logic             protect;

`ifdef MARIO_PWR_HURT_GRACE_EN
  localparam logic [CNT_W-1:0] HURT_LD = CNT_W'(HURT_TICKS);
  logic [CNT_W-1:0] hurt_q, hurt_d;
  assign blink   = (hurt_q != CNT_ZERO);
  assign protect = hero | blink;
`else
  assign blink   = 1'b0;
  assign protect = hero;
`endif

  always_comb begin
    state_d = state_q;
    star_d  = star_q;
`ifdef MARIO_PWR_HURT_GRACE_EN
    hurt_d  = hurt_q;
`endif
    up_d    = 1'b0;
    dn_d    = 1'b0;
    hr_d    = 1'b0;
    if (state_q == DEAD) begin
      if (respawn) begin
        state_d = SMALL;
        star_d  = CNT_ZERO;
`ifdef MARIO_PWR_HURT_GRACE_EN
        hurt_d  = CNT_ZERO;
`endif
      end
    end else begin
      // Decrement first so that any load below overrides it.
      if (tick && star_q != CNT_ZERO) star_d = star_q - CNT_ONE;
`ifdef MARIO_PWR_HURT_GRACE_EN
      if (tick && hurt_q != CNT_ZERO) hurt_d = hurt_q - CNT_ONE;
`endif
      if (fall_pit) begin
        state_d = DEAD;
        star_d  = CNT_ZERO;
`ifdef MARIO_PWR_HURT_GRACE_EN
        hurt_d  = CNT_ZERO;
`endif
      end else if (get_star) begin
        star_d = STAR_LD;
        hr_d   = 1'b1;
      end else if (enemy_hit) begin
        // A blocked hit still consumes the cycle's event slot.
        if (!protect) begin
          if (state_q == BIG) begin
            state_d = SMALL;
            dn_d    = 1'b1;
`ifdef MARIO_PWR_HURT_GRACE_EN
            hurt_d  = HURT_LD;
`endif
          end else begin
            state_d = DEAD;
            star_d  = CNT_ZERO;
`ifdef MARIO_PWR_HURT_GRACE_EN
            hurt_d  = CNT_ZERO;
`endif
          end
        end
      end else if (get_mushroom) begin
        if (state_q == SMALL) begin
          state_d = BIG;
          up_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= SMALL;
      star_q  <= CNT_ZERO;
`ifdef MARIO_PWR_HURT_GRACE_EN
      hurt_q  <= CNT_ZERO;
`endif
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      hr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      star_q  <= star_d;
`ifdef MARIO_PWR_HURT_GRACE_EN
      hurt_q  <= hurt_d;
`endif
      up_q    <= up_d;
      dn_q    <= dn_d;
      hr_q    <= hr_d;
    end
  end

  assign upgrade_impulse   = up_q;
  assign downgrade_impulse = dn_q;
  assign hero_impulse      = hr_q;
  assign level             = (state_q == BIG);
  assign dead              = (state_q == DEAD);
  assign hero              = (star_q != CNT_ZERO);

endmodule

// File: tb/tb_mario_power_ctrl.sv
// tb/tb_mario_power_ctrl.sv - Directed table-driven bench for mario_power_ctrl.
module tb_mario_power_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic tick = 1'b0, get_mushroom = 1'b0, get_star = 1'b0;
  logic enemy_hit = 1'b0, fall_pit = 1'b0, respawn = 1'b0;
  logic upgrade_impulse, downgrade_impulse, hero_impulse;
  logic level, hero, blink, dead;

  int checks = 0;
  int errors = 0;

`ifdef MARIO_PWR_HURT_GRACE_EN
  localparam logic GRACE = 1'b1;
`else
  localparam logic GRACE = 1'b0;
`endif

  // Event bits: {tick, mushroom, star, hit, fall, respawn}
  localparam logic [5:0] E_IDLE = 6'b000000;
  localparam logic [5:0] E_TICK = 6'b100000;
  localparam logic [5:0] E_MUSH = 6'b010000;
  localparam logic [5:0] E_STAR = 6'b001000;
  localparam logic [5:0] E_HIT  = 6'b000100;
  localparam logic [5:0] E_FALL = 6'b000010;
  localparam logic [5:0] E_RESP = 6'b000001;

  typedef struct {
    logic [5:0] ev;
    logic [6:0] exp;   // {up, dn, hero_imp, level, hero, blink, dead}
    string      name;
  } vec_t;

  vec_t tbl[14];

  mario_power_ctrl dut (
    .clk               (clk),
    .rstn              (rstn),
    .tick              (tick),
    .get_mushroom      (get_mushroom),
    .get_star          (get_star),
    .enemy_hit         (enemy_hit),
    .fall_pit          (fall_pit),
    .respawn           (respawn),
    .upgrade_impulse   (upgrade_impulse),
    .downgrade_impulse (downgrade_impulse),
    .hero_impulse      (hero_impulse),
    .level             (level),
    .hero              (hero),
    .blink             (blink),
    .dead              (dead)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {upgrade_impulse, downgrade_impulse, hero_impulse, level, hero, blink, dead};
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = obs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got up/dn/hr/lvl/hero/blink/dead=%b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of events across a rising edge, leave outputs settled after it.
  task automatic cyc(input logic [5:0] ev);
    {tick, get_mushroom, get_star, enemy_hit, fall_pit, respawn} = ev;
    @(posedge clk);
    #1;
    {tick, get_mushroom, get_star, enemy_hit, fall_pit, respawn} = E_IDLE;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(E_TICK);
  endtask

  initial begin
    tbl[0]  = '{E_MUSH,          7'b1001000, "first_mushroom"};
    tbl[1]  = '{E_IDLE,          7'b0001000, "upgrade_drops"};
    tbl[2]  = '{E_MUSH,          7'b0001000, "mushroom_in_big"};
    tbl[3]  = '{E_HIT,           {5'b01000, GRACE, 1'b0}, "hit_in_big"};
    tbl[4]  = '{E_IDLE,          {5'b00000, GRACE, 1'b0}, "downgrade_drops"};
    tbl[5]  = '{E_RESP,          7'b0000000, "respawn_small"};
    tbl[6]  = '{E_STAR | E_HIT,  7'b0010100, "star_beats_hit"};
    tbl[7]  = '{E_IDLE,          7'b0000100, "hero_impulse_drops"};
    tbl[8]  = '{E_HIT,           7'b0000100, "hit_while_hero"};
    tbl[9]  = '{E_MUSH,          7'b1001100, "mushroom_while_hero"};
    tbl[10] = '{E_FALL | E_STAR, 7'b0000001, "fall_beats_star"};
    tbl[11] = '{E_MUSH,          7'b0000001, "mushroom_in_dead"};
    tbl[12] = '{E_TICK,          7'b0000001, "tick_in_dead"};
    tbl[13] = '{E_RESP,          7'b0000000, "respawn_again"};

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 7'b0000000);
    rstn = 1'b1;
    cyc(E_IDLE);
    check("idle_after_reset", 7'b0000000);

    for (int i = 0; i < 5; i++) begin
      cyc(tbl[i].ev);
      check(tbl[i].name, tbl[i].exp);
    end

`ifdef MARIO_PWR_HURT_GRACE_EN
    ticks(5);
    cyc(E_HIT);
    check("hit_during_grace", 7'b0000010);
    ticks(114);
    check("grace_tick_119", 7'b0000010);
    cyc(E_TICK);
    check("grace_tick_120", 7'b0000000);
    cyc(E_HIT);
    check("hit_after_grace", 7'b0000001);
`else
    cyc(E_HIT);
    check("second_hit_kills", 7'b0000001);
`endif

    for (int i = 5; i < 14; i++) begin
      cyc(tbl[i].ev);
      check(tbl[i].name, tbl[i].exp);
    end

    cyc(E_STAR);
    check("star_load", 7'b0010100);
    ticks(300);
    check("star_300_ticks", 7'b0000100);
    cyc(E_STAR);
    check("star_reload", 7'b0010100);
    ticks(599);
    check("star_reload_599", 7'b0000100);
    cyc(E_TICK);
    check("star_reload_600", 7'b0000000);
    ticks(2);
    check("star_no_wrap", 7'b0000000);

    cyc(E_STAR);
    check("star_before_reset", 7'b0010100);
    rstn = 1'b0;
    #1;
    check("async_reset", 7'b0000000);
    @(negedge clk);
    rstn = 1'b1;
    cyc(E_IDLE);
    check("after_async_reset", 7'b0000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
